// File: rtl/tmr_pkg.sv
// Shared types for the triple-modular-redundant sequential multiplier.
// Holds the controller state encoding and the fault_id codes.
package tmr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StVote,
    StOut
  } state_e;

  localparam logic [1:0] FID_NONE = 2'd0;
  localparam logic [1:0] FID_R1   = 2'd1;
  localparam logic [1:0] FID_R2   = 2'd2;
  localparam logic [1:0] FID_R3   = 2'd3;

endpackage

// File: rtl/multiplier.sv
// Signed fixed-point multiplier: full 2N-bit product, Q(INTBITS.FRACBITS) result slice
// and an overflow flag when the discarded high bits are not a pure sign extension.
module multiplier #(
  parameter int unsigned N        = 16,
  parameter int unsigned INTBITS  = 6,
  parameter int unsigned FRACBITS = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] res,
  output logic         ovf
);

  localparam int unsigned HiW = INTBITS + 1;

  logic signed [2*N-1:0] a_ext, b_ext, prod;
  logic [HiW-1:0]        hi;
  logic                  unused_frac;

  assign a_ext = {{N{a[N-1]}}, a};
  assign b_ext = {{N{b[N-1]}}, b};
  assign prod  = a_ext * b_ext;

  assign res = prod[N-1+FRACBITS -: N];
  // Bits above the result's sign bit, plus the sign bit itself, must all agree.
  assign hi  = prod[2*N-1 -: HiW];
  assign ovf = !((&hi) || (~|hi));

  assign unused_frac = ^prod[FRACBITS-1:0];

endmodule

// File: rtl/tmr_seq_multiplier.sv
// Triple-redundant fixed-point multiplier with majority voting, bounded retry on
// total disagreement, per-replica saturating error counters and a fault-injection hook.
module tmr_seq_multiplier
  import tmr_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned INTBITS   = 6,
  parameter int unsigned FRACBITS  = 10,
  parameter int unsigned RETRY_MAX = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       result,
  output logic               ovf,
  output logic               invalid,
  output logic [1:0]         fault_id,
  output logic [2:0]         retries,
  output logic [3*CNT_W-1:0] err_cnt,
  input  logic               clr_cnt,
  input  logic               inj_en,
  input  logic [1:0]         inj_sel,
  input  logic [N-1:0]       inj_mask
);

  state_e                state_q, state_d;
  logic [2:0]            retry_q, retry_d;
  logic [N-1:0]          a_q, b_q;
  logic [2:0][N-1:0]     rep_res, cap_res;
  logic [2:0]            rep_ovf, cap_ovf;
  logic [2:0][CNT_W-1:0] cnt_q;
  logic                  eq01, eq02, eq12;
  logic                  load_out;
  logic [N-1:0]          result_d;
  logic                  ovf_d, invalid_d;
  logic [1:0]            fid_d;
  logic [2:0]            inc;

  for (genvar k = 0; k < 3; k++) begin : g_rep
    multiplier #(
      .N       (N),
      .INTBITS (INTBITS),
      .FRACBITS(FRACBITS)
    ) u_rep (
      .a  (a_q),
      .b  (b_q),
      .res(rep_res[k]),
      .ovf(rep_ovf[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_res <= '0;
      cap_ovf <= '0;
    end else if (state_q == StMul) begin
      for (int k = 0; k < 3; k++) begin
        // Injection corrupts only the result bits; ovf stays as computed.
        cap_res[k] <= rep_res[k] ^ ((inj_en && inj_sel == 2'(k + 1)) ? inj_mask : '0);
        cap_ovf[k] <= rep_ovf[k];
      end
    end
  end

  assign eq01 = {cap_res[0], cap_ovf[0]} == {cap_res[1], cap_ovf[1]};
  assign eq02 = {cap_res[0], cap_ovf[0]} == {cap_res[2], cap_ovf[2]};
  assign eq12 = {cap_res[1], cap_ovf[1]} == {cap_res[2], cap_ovf[2]};

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    load_out  = 1'b0;
    result_d  = cap_res[0];
    ovf_d     = cap_ovf[0];
    invalid_d = 1'b0;
    fid_d     = FID_NONE;
    inc       = '0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StMul;
          retry_d = '0;
        end
      end
      StMul: state_d = StVote;
      StVote: begin
        state_d  = StOut;
        load_out = 1'b1;
        if (eq01 && eq02) begin
          fid_d = FID_NONE;
        end else if (eq01) begin
          fid_d  = FID_R3;
          inc[2] = 1'b1;
        end else if (eq02) begin
          fid_d  = FID_R2;
          inc[1] = 1'b1;
        end else if (eq12) begin
          result_d = cap_res[1];
          ovf_d    = cap_ovf[1];
          fid_d    = FID_R1;
          inc[0]   = 1'b1;
        end else if (retry_q < 3'(RETRY_MAX)) begin
          state_d  = StMul;
          retry_d  = retry_q + 3'd1;
          load_out = 1'b0;
        end else begin
          invalid_d = 1'b1;
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      retry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (state_q == StIdle && in_valid) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      ovf      <= 1'b0;
      invalid  <= 1'b0;
      fault_id <= FID_NONE;
      retries  <= '0;
    end else if (load_out) begin
      result   <= result_d;
      ovf      <= ovf_d;
      invalid  <= invalid_d;
      fault_id <= fid_d;
      retries  <= retry_q;
    end
  end

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (inc[k] && cnt_q[k] != {CNT_W{1'b1}}) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  assign err_cnt   = cnt_q;
  assign out_valid = (state_q == StOut);
  assign in_ready  = rst_n && (state_q == StIdle);

endmodule

// File: tb/tb_tmr_seq_multiplier.sv
// Directed, table-driven bench for tmr_seq_multiplier with hand-computed expectations
// plus sequences for retry/invalid, output stall, counter clear, mid-flight reset and saturation.
module tb_tmr_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result, inj_mask;
  logic        ovf, invalid, clr_cnt, inj_en;
  logic [1:0]  fault_id, inj_sel;
  logic [2:0]  retries;
  logic [23:0] err_cnt;

  int total = 0;
  int bad   = 0;

  tmr_seq_multiplier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf),
    .invalid  (invalid),
    .fault_id (fault_id),
    .retries  (retries),
    .err_cnt  (err_cnt),
    .clr_cnt  (clr_cnt),
    .inj_en   (inj_en),
    .inj_sel  (inj_sel),
    .inj_mask (inj_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ie;
    logic [1:0]  is;
    logic [15:0] im;
    logic [15:0] res;
    logic        ovf;
    logic [1:0]  fid;
  } vec_t;

  vec_t vecs[9];
  int   exp_cnt[3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Returns the edge index (relative to the accept edge) that first samples out_valid=1.
  task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb, input logic ie,
                        input logic [1:0] is, input logic [15:0] im, output int seen);
    @(negedge clk);
    a = ta; b = tb; inj_en = ie; inj_sel = is; inj_mask = im; in_valid = 1'b1;
    @(posedge clk);
    seen = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && seen < 30) begin
      @(posedge clk);
      seen++;
      @(negedge clk);
    end
    seen = seen + 1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    inj_en    = 1'b0;
    inj_sel   = 2'd0;
    inj_mask  = '0;
  endtask

  task automatic check_cnt(input string name);
    check({name, ".cnt1"}, err_cnt[7:0],   8'(exp_cnt[0]));
    check({name, ".cnt2"}, err_cnt[15:8],  8'(exp_cnt[1]));
    check({name, ".cnt3"}, err_cnt[23:16], 8'(exp_cnt[2]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic saw_valid;

    //        a         b         ie    is    im        res       ovf   fid
    vecs[0] = '{16'h0400, 16'h0C00, 1'b0, 2'd0, 16'h0000, 16'h0C00, 1'b0, 2'd0};
    vecs[1] = '{16'h7C00, 16'h0800, 1'b0, 2'd0, 16'h0000, 16'hF800, 1'b1, 2'd0};
    vecs[2] = '{16'h0400, 16'h0400, 1'b1, 2'd2, 16'h0001, 16'h0400, 1'b0, 2'd2};
    vecs[3] = '{16'hFC00, 16'h0C00, 1'b0, 2'd0, 16'h0000, 16'hF400, 1'b0, 2'd0};
    vecs[4] = '{16'h0200, 16'h0200, 1'b1, 2'd1, 16'h00FF, 16'h0100, 1'b0, 2'd1};
    vecs[5] = '{16'h0600, 16'hFE00, 1'b1, 2'd3, 16'h8000, 16'hFD00, 1'b0, 2'd3};
    vecs[6] = '{16'h0001, 16'h0001, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 2'd0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 2'd0};
    vecs[8] = '{16'h0400, 16'h0C00, 1'b1, 2'd0, 16'hFFFF, 16'h0C00, 1'b0, 2'd0};
    exp_cnt = '{0, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    clr_cnt = 1'b0; inj_en = 1'b0; inj_sel = '0; inj_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.result", result, 0);
    check("rst.flags", {ovf, invalid, fault_id, retries}, 0);
    check_cnt("rst");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst.in_ready_after", in_ready, 1);

    foreach (vecs[i]) begin
      check($sformatf("v%0d.in_ready", i), in_ready, 1);
      do_txn(vecs[i].a, vecs[i].b, vecs[i].ie, vecs[i].is, vecs[i].im, seen);
      if (vecs[i].fid != 2'd0) exp_cnt[vecs[i].fid - 1]++;
      check($sformatf("v%0d.latency", i), seen, 3);
      check($sformatf("v%0d.result", i), result, vecs[i].res);
      check($sformatf("v%0d.ovf", i), ovf, vecs[i].ovf);
      check($sformatf("v%0d.fid", i), fault_id, vecs[i].fid);
      check($sformatf("v%0d.inv_retries", i), {invalid, retries}, 0);
      check_cnt($sformatf("v%0d", i));
      handshake();
    end

    // Every attempt sees three distinct replica values.
    force dut.cap_res = {16'h0003, 16'h0002, 16'h0001};
    do_txn(16'h0400, 16'h0400, 1'b0, 2'd0, 16'h0000, seen);
    check("retry.latency", seen, 7);
    check("retry.retries", retries, 2);
    check("retry.invalid", invalid, 1);
    check("retry.result", result, 16'h0001);
    check("retry.fid_ovf", {fault_id, ovf}, 0);
    check_cnt("retry");
    handshake();
    release dut.cap_res;

    do_txn(16'h0400, 16'h0C00, 1'b1, 2'd1, 16'h0010, seen);
    exp_cnt[0]++;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d.valid_ready", i), {out_valid, in_ready}, 2'b10);
      check($sformatf("stall%0d.out", i), {result, ovf, invalid, fault_id, retries},
            {16'h0C00, 1'b0, 1'b0, 2'd1, 3'd0});
      @(negedge clk);
    end
    check_cnt("stall");
    handshake();

    // Reset while the replicas are working.
    @(negedge clk);
    a = 16'h0400; b = 16'h0400; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst.in_ready_low", in_ready, 0);
    saw_valid = out_valid;
    rst_n = 1'b1;
    exp_cnt = '{0, 0, 0};
    @(posedge clk);
    @(negedge clk);
    check("midrst.in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      saw_valid |= out_valid;
      @(negedge clk);
    end
    check("midrst.no_valid", saw_valid, 0);
    check("midrst.outs", {result, ovf, invalid, fault_id, retries}, 0);
    check_cnt("midrst");

    do_txn(16'h0400, 16'h0400, 1'b1, 2'd2, 16'h0001, seen);
    exp_cnt[1]++;
    check_cnt("pre_clr");
    handshake();
    clr_cnt = 1'b1;
    do_txn(16'h0400, 16'h0400, 1'b1, 2'd3, 16'h0001, seen);
    check("clr.fid", fault_id, 3);
    exp_cnt = '{0, 0, 0};
    check_cnt("clr");
    handshake();
    clr_cnt = 1'b0;

    for (int i = 0; i < 260; i++) begin
      do_txn(16'h0400, 16'h0400, 1'b1, 2'd3, 16'h0001, seen);
      handshake();
      if (i == 254) check("sat.at_max", err_cnt[23:16], 8'hFF);
    end
    check("sat.sticks", err_cnt[23:16], 8'hFF);
    check("sat.others", err_cnt[15:0], 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
